// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared constants and types for the load/store unit
package lsu_pkg;

    // RV32I load/store width/sign codes
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'b00,
        ERR_MISALIGN = 2'b01,
        ERR_FUNCT3   = 2'b10,
        ERR_TIMEOUT  = 2'b11
    } err_t;

    // Stores only have the signed widths; loads add the unsigned variants.
    function automatic logic f3_legal(input logic write, input logic [2:0] f3);
        logic ok;
        ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        if (!write) begin
            ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
        end
        return ok;
    endfunction

endpackage

// File: rtl/lsu_if.sv
// rtl/lsu_if.sv - core-side and memory-side bundles of the load/store unit
//
// lsu_req_if : core request (req_valid/req_write/funct3/addr/wdata) and
//              response (stall/done/rdata/err). master = core, slave = LSU.
// lsu_mem_if : word-aligned memory request (mem_req/mem_we/mem_addr/mem_be/
//              mem_wdata) and response (mem_ready/mem_rdata).
//              master = LSU, slave = memory.
interface lsu_req_if;
    logic        req_valid;
    logic        req_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic        done;
    logic [31:0] rdata;
    logic [1:0]  err;

    modport master (
        output req_valid, req_write, funct3, addr, wdata,
        input  stall, done, rdata, err
    );
    modport slave (
        input  req_valid, req_write, funct3, addr, wdata,
        output stall, done, rdata, err
    );
endinterface

interface lsu_mem_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ready, mem_rdata
    );
    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - combinational byte-lane steering and request checks
//
// Ports:
//   funct3, write, addr_lo : request width code, store flag, addr[1:0]
//   wdata                  : store data before replication
//   mem_rdata              : raw memory word
//   be, wdata_rep          : byte enables and lane-replicated store data
//   load_val               : selected lane, sign/zero extended (0 for stores)
//   misaligned, illegal    : request check flags
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic        write,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] mem_rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] load_val,
    output logic        misaligned,
    output logic        illegal
);

    logic [31:0] shifted;

    assign shifted = mem_rdata >> {addr_lo, 3'b000};
    assign illegal = !f3_legal(write, funct3);

    always_comb begin
        be         = 4'b0000;
        wdata_rep  = 32'h0;
        misaligned = 1'b0;
        unique case (funct3)
            F3_B, F3_BU: begin
                be        = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
            end
            F3_H, F3_HU: begin
                be         = 4'b0011 << addr_lo;
                wdata_rep  = {2{wdata[15:0]}};
                misaligned = addr_lo[0];
            end
            F3_W: begin
                be         = 4'b1111;
                wdata_rep  = wdata;
                misaligned = (addr_lo != 2'b00);
            end
            default: begin
                be        = 4'b0000;
                wdata_rep = 32'h0;
            end
        endcase
    end

    always_comb begin
        load_val = 32'h0;
        if (!write) begin
            unique case (funct3)
                F3_B:    load_val = {{24{shifted[7]}}, shifted[7:0]};
                F3_H:    load_val = {{16{shifted[15]}}, shifted[15:0]};
                F3_W:    load_val = shifted;
                F3_BU:   load_val = {24'h0, shifted[7:0]};
                F3_HU:   load_val = {16'h0, shifted[15:0]};
                default: load_val = 32'h0;
            endcase
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I load/store unit with timeout
//
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   core       : lsu_req_if.slave  - request in, stall/done/rdata/err out
//   mem        : lsu_mem_if.master - word-aligned memory request/response
// Parameter TIMEOUT_CYCLES : BUSY cycles allowed without mem_ready.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic reset,
    lsu_req_if.slave  core,
    lsu_mem_if.master mem
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t            state;
    err_t              err_q;
    logic [CNT_W-1:0]  cnt;
    logic [31:0]       rdata_q;
    logic              done_q;
    logic [31:0]       addr_q;
    logic [31:0]       wdata_q;
    logic [2:0]        funct3_q;
    logic              write_q;

    logic              idle;
    logic [2:0]        al_funct3;
    logic              al_write;
    logic [1:0]        al_addr_lo;
    logic [31:0]       al_wdata;
    logic [3:0]        al_be;
    logic [31:0]       al_wdata_rep;
    logic [31:0]       al_load_val;
    logic              al_misaligned;
    logic              al_illegal;

    // In IDLE the aligner checks the incoming request; afterwards it works
    // from the latched copy so the memory-side outputs stay stable.
    assign idle       = (state == S_IDLE);
    assign al_funct3  = idle ? core.funct3    : funct3_q;
    assign al_write   = idle ? core.req_write : write_q;
    assign al_addr_lo = idle ? core.addr[1:0] : addr_q[1:0];
    assign al_wdata   = idle ? core.wdata     : wdata_q;

    lsu_align u_align (
        .funct3     (al_funct3),
        .write      (al_write),
        .addr_lo    (al_addr_lo),
        .wdata      (al_wdata),
        .mem_rdata  (mem.mem_rdata),
        .be         (al_be),
        .wdata_rep  (al_wdata_rep),
        .load_val   (al_load_val),
        .misaligned (al_misaligned),
        .illegal    (al_illegal)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            err_q    <= ERR_NONE;
            cnt      <= '0;
            rdata_q  <= 32'h0;
            done_q   <= 1'b0;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            funct3_q <= 3'b000;
            write_q  <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (core.req_valid) begin
                        if (al_illegal) begin
                            state   <= S_ERR;
                            err_q   <= ERR_FUNCT3;
                            rdata_q <= 32'h0;
                            done_q  <= 1'b1;
                        end else if (al_misaligned) begin
                            state   <= S_ERR;
                            err_q   <= ERR_MISALIGN;
                            rdata_q <= 32'h0;
                            done_q  <= 1'b1;
                        end else begin
                            state    <= S_BUSY;
                            cnt      <= '0;
                            addr_q   <= core.addr;
                            wdata_q  <= core.wdata;
                            funct3_q <= core.funct3;
                            write_q  <= core.req_write;
                        end
                    end
                end
                S_BUSY: begin
                    // mem_ready beats the timeout when both land together
                    if (mem.mem_ready) begin
                        state   <= S_DONE;
                        err_q   <= ERR_NONE;
                        rdata_q <= al_load_val;
                        done_q  <= 1'b1;
                    end else if (cnt == CNT_LIMIT) begin
                        state   <= S_ERR;
                        err_q   <= ERR_TIMEOUT;
                        rdata_q <= 32'h0;
                        done_q  <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DONE, S_ERR: begin
                    state  <= S_IDLE;
                    done_q <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign core.stall = (idle && core.req_valid) || (state == S_BUSY);
    assign core.done  = done_q;
    assign core.rdata = rdata_q;
    assign core.err   = err_q;

    assign mem.mem_req   = (state == S_BUSY);
    assign mem.mem_we    = (state == S_BUSY) && write_q;
    assign mem.mem_addr  = {addr_q[31:2], 2'b00};
    assign mem.mem_be    = (state == S_BUSY) ? al_be : 4'b0000;
    assign mem.mem_wdata = (state == S_BUSY) ? al_wdata_rep : 32'h0;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit
module tb_load_store_unit;

    typedef struct packed {
        logic [31:0] rdata;
        logic [1:0]  err;
    } resp_t;

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    resp_t exp_q[$];

    lsu_req_if core_if ();
    lsu_mem_if mem_if ();

    load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk   (clk),
        .reset (reset),
        .core  (core_if),
        .mem   (mem_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One core request; ready_at = BUSY cycle on which mem_ready is raised
    // (0 = never). exp_busy = BUSY cycles expected (0 for IDLE-time errors).
    task automatic txn(input string tag, input logic w, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       input int ready_at, input logic [31:0] md,
                       input logic [3:0] exp_be, input logic [31:0] exp_wd,
                       input logic [31:0] exp_rd, input logic [1:0] exp_err,
                       input int exp_busy);
        resp_t r;
        int    busy;
        int    edges;
        bit    seen;
        core_if.req_valid = 1'b1;
        core_if.req_write = w;
        core_if.funct3    = f3;
        core_if.addr      = a;
        core_if.wdata     = wd;
        mem_if.mem_ready  = 1'b0;
        mem_if.mem_rdata  = md;
        exp_q.push_back('{rdata: exp_rd, err: exp_err});
        #1;
        chk({tag, ".stall_idle"}, 32'(core_if.stall), 32'd1);
        busy  = 0;
        edges = 0;
        seen  = 0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(posedge clk);
            #1;
            edges++;
            if (mem_if.mem_req) begin
                busy++;
                chk({tag, ".addr"}, mem_if.mem_addr, {a[31:2], 2'b00});
                chk({tag, ".be"}, 32'(mem_if.mem_be), 32'(exp_be));
                chk({tag, ".wdata"}, mem_if.mem_wdata, exp_wd);
                chk({tag, ".we"}, 32'(mem_if.mem_we), 32'(w));
                chk({tag, ".stall_busy"}, 32'(core_if.stall), 32'd1);
                mem_if.mem_ready = (busy == ready_at);
            end
            if (core_if.done) begin
                seen = 1;
                r = exp_q.pop_front();
                chk({tag, ".rdata"}, core_if.rdata, r.rdata);
                chk({tag, ".err"}, 32'(core_if.err), 32'(r.err));
                chk({tag, ".stall_done"}, 32'(core_if.stall), 32'd0);
                chk({tag, ".busy_cycles"}, 32'(busy), 32'(exp_busy));
                chk({tag, ".latency"}, 32'(edges), 32'(exp_busy + 1));
                core_if.req_valid = 1'b0;
                mem_if.mem_ready  = 1'b0;
                @(posedge clk);
                #1;
                chk({tag, ".done_pulse"}, 32'(core_if.done), 32'd0);
                chk({tag, ".no_reissue"}, 32'(mem_if.mem_req), 32'd0);
            end
        end
        if (!seen) begin
            checks++;
            failures++;
            $error("FAIL %s.done_timeout observed=no_done expected=done", tag);
            core_if.req_valid = 1'b0;
            mem_if.mem_ready  = 1'b0;
            exp_q.delete();
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        core_if.req_valid = 1'b0;
        core_if.req_write = 1'b0;
        core_if.funct3    = 3'b000;
        core_if.addr      = 32'h0;
        core_if.wdata     = 32'h0;
        mem_if.mem_ready  = 1'b0;
        mem_if.mem_rdata  = 32'h0;

        @(posedge clk);
        #1;
        chk("reset.done", 32'(core_if.done), 32'd0);
        chk("reset.mem_req", 32'(mem_if.mem_req), 32'd0);
        chk("reset.rdata", core_if.rdata, 32'h0);
        chk("reset.err", 32'(core_if.err), 32'd0);
        chk("reset.stall", 32'(core_if.stall), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        //   tag     w  f3      addr         wdata        rdy md            be       mem_wdata     rdata         err    busy
        txn("lw",   0, 3'b010, 32'h100, 32'h0,        1, 32'hDEADBEEF, 4'b1111, 32'h0,        32'hDEADBEEF, 2'b00, 1);
        txn("lb",   0, 3'b000, 32'h103, 32'h0,        1, 32'h80FFFF7F, 4'b1000, 32'h0,        32'hFFFFFF80, 2'b00, 1);
        txn("lbu",  0, 3'b100, 32'h103, 32'h0,        1, 32'h80FFFF7F, 4'b1000, 32'h0,        32'h00000080, 2'b00, 1);
        txn("lh",   0, 3'b001, 32'h102, 32'h0,        1, 32'h80FFFF7F, 4'b1100, 32'h0,        32'hFFFF80FF, 2'b00, 1);
        txn("lhu",  0, 3'b101, 32'h102, 32'h0,        2, 32'h80FFFF7F, 4'b1100, 32'h0,        32'h000080FF, 2'b00, 2);
        txn("lb0",  0, 3'b000, 32'h100, 32'h0,        1, 32'h80FFFF7F, 4'b0001, 32'h0,        32'h0000007F, 2'b00, 1);
        txn("sb",   1, 3'b000, 32'h201, 32'h000000AB, 1, 32'h55555555, 4'b0010, 32'hABABABAB, 32'h0,        2'b00, 1);
        txn("sh",   1, 3'b001, 32'h202, 32'h1234CDEF, 3, 32'h55555555, 4'b1100, 32'hCDEFCDEF, 32'h0,        2'b00, 3);
        txn("sw",   1, 3'b010, 32'h300, 32'h12345678, 1, 32'h55555555, 4'b1111, 32'h12345678, 32'h0,        2'b00, 1);
        txn("lw_mis",  0, 3'b010, 32'h102, 32'h0,     1, 32'hDEADBEEF, 4'b0000, 32'h0,        32'h0,        2'b01, 0);
        txn("lh_mis",  0, 3'b001, 32'h101, 32'h0,     1, 32'hDEADBEEF, 4'b0000, 32'h0,        32'h0,        2'b01, 0);
        txn("ld_f3",   0, 3'b011, 32'h100, 32'h0,     1, 32'hDEADBEEF, 4'b0000, 32'h0,        32'h0,        2'b10, 0);
        txn("st_f3",   1, 3'b100, 32'h100, 32'h0,     1, 32'hDEADBEEF, 4'b0000, 32'h0,        32'h0,        2'b10, 0);
        txn("f3_prio", 0, 3'b110, 32'h101, 32'h0,     1, 32'hDEADBEEF, 4'b0000, 32'h0,        32'h0,        2'b10, 0);
        txn("tmo",     0, 3'b010, 32'h400, 32'h0,     0, 32'hCAFEF00D, 4'b1111, 32'h0,        32'h0,        2'b11, 4);
        txn("tmo_win", 0, 3'b010, 32'h400, 32'h0,     4, 32'hCAFEF00D, 4'b1111, 32'h0,        32'hCAFEF00D, 2'b00, 4);

        // mem_ready outside BUSY must not produce a completion
        mem_if.mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_ready.done", 32'(core_if.done), 32'd0);
        chk("idle_ready.mem_req", 32'(mem_if.mem_req), 32'd0);
        mem_if.mem_ready = 1'b0;

        // reset in the 2nd BUSY cycle
        core_if.req_valid = 1'b1;
        core_if.req_write = 1'b0;
        core_if.funct3    = 3'b010;
        core_if.addr      = 32'h500;
        @(posedge clk);
        #1;
        chk("rst_mid.busy1", 32'(mem_if.mem_req), 32'd1);
        @(posedge clk);
        #1;
        chk("rst_mid.busy2", 32'(mem_if.mem_req), 32'd1);
        reset = 1'b1;
        core_if.req_valid = 1'b0;
        #1;
        chk("rst_mid.mem_req", 32'(mem_if.mem_req), 32'd0);
        chk("rst_mid.done", 32'(core_if.done), 32'd0);
        chk("rst_mid.rdata", core_if.rdata, 32'h0);
        chk("rst_mid.err", 32'(core_if.err), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        txn("lw_post", 0, 3'b010, 32'h600, 32'h0,     1, 32'h0BADF00D, 4'b1111, 32'h0,        32'h0BADF00D, 2'b00, 1);

        chk("scoreboard.empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
